// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the load/store execution unit.
// Holds the FSM state encoding, load/store opcode values, label width default
// and the queue-slot label constants QUE0..QUE2 used on the CDB.
package mem_access_unit_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACCESS   = 2'd1,
    WAIT_CDB = 2'd2
  } state_e;

  localparam logic OP_LOAD  = 1'b1;
  localparam logic OP_STORE = 1'b0;

  localparam int LABEL_W_DEF = 4;

  // Queue-slot labels; the MSB marks a load/store-queue producer so that
  // label 0 can keep meaning "no pending producer" elsewhere in the core.
  localparam logic [LABEL_W_DEF-1:0] QUE0 = 4'd8;
  localparam logic [LABEL_W_DEF-1:0] QUE1 = 4'd9;
  localparam logic [LABEL_W_DEF-1:0] QUE2 = 4'd10;

  // Access counter width; covers the full 1..15 latency range.
  localparam int CNT_W = 4;

endpackage

// File: rtl/mem_access_unit_mem.sv
// Purpose: DEPTH x 32 data RAM, synchronous write, combinational read, sync clear.
// Latency: write lands at the clock edge; read data is valid in the same cycle.
// Backpressure: none; a write is taken whenever we_i is high.
// Ports: clk, nRST (sync active-low clear of all words), we_i/waddr_i/wdata_i
//        write port, raddr_i/rdata_o read port.
module mem_array #(
  parameter int DEPTH = 16,
  parameter int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             nRST,
  input  logic             we_i,
  input  logic [IDX_W-1:0] waddr_i,
  input  logic [31:0]      wdata_i,
  input  logic [IDX_W-1:0] raddr_i,
  output logic [31:0]      rdata_o
);

  logic [31:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (!nRST) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/mem_access_unit.sv
// Purpose: load/store execution unit draining the LSQ head into a private data RAM.
// Latency: LATENCY ACCESS cycles per op; loads then hold a CDB request until granted.
// Backpressure: available=0 outside IDLE; a load stalls in WAIT_CDB until cdbGrant.
// Ports: require/op/baseIn/offsetIn/writeData/labelIn from the queue head,
//        available/isLastState back to the queue, cdbReq/cdbGrant/cdbLabel/cdbData
//        towards the CDB arbiter.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int LATENCY = 3,
  parameter int LABEL_W = LABEL_W_DEF
) (
  input  logic               clk,
  input  logic               nRST,
  input  logic               require,
  input  logic               op,
  input  logic [31:0]        baseIn,
  input  logic [31:0]        offsetIn,
  input  logic [31:0]        writeData,
  input  logic [LABEL_W-1:0] labelIn,
  output logic               available,
  output logic               isLastState,
  output logic               cdbReq,
  input  logic               cdbGrant,
  output logic [LABEL_W-1:0] cdbLabel,
  output logic [31:0]        cdbData
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               op_q, op_d;
  logic [LABEL_W-1:0] label_q, label_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [LABEL_W-1:0] cdb_label_q, cdb_label_d;
  logic [31:0]        cdb_data_q, cdb_data_d;

  logic [31:0]        addr_sum;
  logic               addr_hi_unused;
  logic               accept;
  logic               last_cycle;
  logic               mem_we;
  logic [31:0]        mem_rdata;

  // Address arithmetic wraps at 2^32; only the low index bits select a word.
  assign addr_sum       = baseIn + offsetIn;
  assign addr_hi_unused = ^addr_sum[31:IDX_W];

  assign accept     = (state_q == IDLE) && require;
  assign last_cycle = (state_q == ACCESS) && (cnt_q == '0);

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (!nRST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (require) state_d = ACCESS;
      ACCESS:   if (cnt_q == '0) state_d = (op_q == OP_LOAD) ? WAIT_CDB : IDLE;
      WAIT_CDB: if (cdbGrant) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    available   = 1'b0;
    isLastState = 1'b0;
    cdbReq      = 1'b0;
    mem_we      = 1'b0;
    unique case (state_q)
      IDLE:     available = 1'b1;
      ACCESS: begin
        isLastState = (cnt_q == '0);
        mem_we      = (cnt_q == '0) && (op_q == OP_STORE);
      end
      WAIT_CDB: cdbReq = 1'b1;
      default:  available = 1'b0;
    endcase
  end

  // ---------------- Datapath next-state ----------------
  always_comb begin
    cnt_d       = cnt_q;
    op_d        = op_q;
    label_d     = label_q;
    wdata_d     = wdata_q;
    idx_d       = idx_q;
    cdb_label_d = cdb_label_q;
    cdb_data_d  = cdb_data_q;

    if (accept) begin
      cnt_d   = CNT_INIT;
      op_d    = op;
      label_d = labelIn;
      wdata_d = writeData;
      idx_d   = addr_sum[IDX_W-1:0];
    end else if ((state_q == ACCESS) && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end

    // CDB payload is captured once and then held untouched through WAIT_CDB.
    if (last_cycle && (op_q == OP_LOAD)) begin
      cdb_label_d = label_q;
      cdb_data_d  = mem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!nRST) begin
      cnt_q       <= '0;
      op_q        <= OP_STORE;
      label_q     <= '0;
      wdata_q     <= '0;
      idx_q       <= '0;
      cdb_label_q <= '0;
      cdb_data_q  <= '0;
    end else begin
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      label_q     <= label_d;
      wdata_q     <= wdata_d;
      idx_q       <= idx_d;
      cdb_label_q <= cdb_label_d;
      cdb_data_q  <= cdb_data_d;
    end
  end

  assign cdbLabel = cdb_label_q;
  assign cdbData  = cdb_data_q;

  mem_array #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_mem (
    .clk     (clk),
    .nRST    (nRST),
    .we_i    (mem_we),
    .waddr_i (idx_q),
    .wdata_i (wdata_q),
    .raddr_i (idx_q),
    .rdata_o (mem_rdata)
  );

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a reference memory model and a
// scoreboard queue of expected CDB broadcasts.
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  localparam int DEPTH = 16;
  localparam int LAT   = 3;
  localparam int LW    = 4;

  logic          clk;
  logic          nRST;
  logic          require;
  logic          op;
  logic [31:0]   baseIn;
  logic [31:0]   offsetIn;
  logic [31:0]   writeData;
  logic [LW-1:0] labelIn;
  logic          available;
  logic          isLastState;
  logic          cdbReq;
  logic          cdbGrant;
  logic [LW-1:0] cdbLabel;
  logic [31:0]   cdbData;

  typedef struct {
    logic [LW-1:0] lab;
    logic [31:0]   dat;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] mmem [DEPTH];
  int          checks = 0;
  int          errors = 0;

  mem_access_unit #(
    .DEPTH   (DEPTH),
    .LATENCY (LAT),
    .LABEL_W (LW)
  ) dut (
    .clk         (clk),
    .nRST        (nRST),
    .require     (require),
    .op          (op),
    .baseIn      (baseIn),
    .offsetIn    (offsetIn),
    .writeData   (writeData),
    .labelIn     (labelIn),
    .available   (available),
    .isLastState (isLastState),
    .cdbReq      (cdbReq),
    .cdbGrant    (cdbGrant),
    .cdbLabel    (cdbLabel),
    .cdbData     (cdbData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic int idx_of(input logic [31:0] b, input logic [31:0] o);
    logic [31:0] s;
    s = b + o;
    return int'(s % DEPTH);
  endfunction

  // One complete operation. gdelay = number of WAIT_CDB cycles without grant;
  // gdelay==0 keeps cdbGrant high from accept onward (ignored until WAIT_CDB).
  task automatic do_op(input string tag, input logic ld, input logic [31:0] b,
                       input logic [31:0] o, input logic [31:0] wd,
                       input logic [LW-1:0] lab, input int gdelay);
    int   ix;
    exp_t e;
    ix = idx_of(b, o);
    chk({tag, ":avail_idle"}, 32'(available), 32'd1);
    require   = 1'b1;
    op        = ld;
    baseIn    = b;
    offsetIn  = o;
    writeData = wd;
    labelIn   = lab;
    cdbGrant  = (gdelay == 0);
    if (ld) begin
      e.lab = lab;
      e.dat = mmem[ix];
      sbq.push_back(e);
    end
    tick();
    require = 1'b0;
    for (int c = 1; c <= LAT; c++) begin
      chk($sformatf("%s:avail_acc%0d", tag, c), 32'(available), 32'd0);
      chk($sformatf("%s:last_acc%0d", tag, c), 32'(isLastState), 32'(c == LAT));
      chk($sformatf("%s:req_acc%0d", tag, c), 32'(cdbReq), 32'd0);
      tick();
    end
    if (!ld) begin
      mmem[ix] = wd;
    end else begin
      for (int g = 0; g <= gdelay; g++) begin
        if (g == gdelay) cdbGrant = 1'b1;
        chk($sformatf("%s:req_w%0d", tag, g), 32'(cdbReq), 32'd1);
        chk($sformatf("%s:avail_w%0d", tag, g), 32'(available), 32'd0);
        if (sbq.size() == 0) begin
          chk({tag, ":sb_empty"}, 32'd1, 32'd0);
        end else begin
          chk($sformatf("%s:lab_w%0d", tag, g), 32'(cdbLabel), 32'(sbq[0].lab));
          chk($sformatf("%s:dat_w%0d", tag, g), cdbData, sbq[0].dat);
        end
        tick();
      end
      if (sbq.size() != 0) void'(sbq.pop_front());
      cdbGrant = 1'b0;
    end
    chk({tag, ":req_after"}, 32'(cdbReq), 32'd0);
    chk({tag, ":last_after"}, 32'(isLastState), 32'd0);
    chk({tag, ":avail_after"}, 32'(available), 32'd1);
  endtask

  initial begin
    nRST      = 1'b0;
    require   = 1'b0;
    op        = OP_STORE;
    baseIn    = '0;
    offsetIn  = '0;
    writeData = '0;
    labelIn   = '0;
    cdbGrant  = 1'b0;
    for (int i = 0; i < DEPTH; i++) mmem[i] = '0;
    tick();
    tick();
    nRST = 1'b1;
    chk("rst:avail", 32'(available), 32'd1);
    chk("rst:last", 32'(isLastState), 32'd0);
    chk("rst:req", 32'(cdbReq), 32'd0);
    chk("rst:label", 32'(cdbLabel), 32'd0);
    chk("rst:data", cdbData, 32'd0);

    // require low in IDLE: nothing happens
    tick();
    chk("idle_hold:avail", 32'(available), 32'd1);

    // Tests 1-3: store, load with grant held, load with grant withheld
    do_op("t1_st",  OP_STORE, 32'd4, 32'd1, 32'hDEADBEEF, QUE1, 0);
    do_op("t2_ld",  OP_LOAD,  32'd0, 32'd5, 32'h0,       QUE1, 0);
    do_op("t3_ld",  OP_LOAD,  32'd2, 32'd3, 32'h0,       QUE2, 5);
    do_op("t3_ldz", OP_LOAD,  32'd7, 32'd0, 32'h0,       QUE0, 1);

    // Test 4: address wrap to index 0
    do_op("t4_st", OP_STORE, 32'hFFFFFFFF, 32'h11, 32'h12345678, QUE0, 2);
    do_op("t4_ld", OP_LOAD,  32'd0, 32'd0, 32'h0, QUE2, 0);

    // Test 5: reset during the 2nd ACCESS cycle of a store to index 3
    do_op("t5_pre", OP_STORE, 32'd3, 32'd0, 32'hCAFEF00D, QUE1, 1);
    require   = 1'b1;
    op        = OP_STORE;
    baseIn    = 32'd1;
    offsetIn  = 32'd2;
    writeData = 32'hA5A5A5A5;
    labelIn   = QUE2;
    tick();
    require = 1'b0;
    chk("t5:last_acc1", 32'(isLastState), 32'd0);
    tick();
    chk("t5:last_acc2", 32'(isLastState), 32'd0);
    nRST = 1'b0;
    tick();
    nRST = 1'b1;
    for (int i = 0; i < DEPTH; i++) mmem[i] = '0;
    chk("t5:avail_post", 32'(available), 32'd1);
    chk("t5:last_post", 32'(isLastState), 32'd0);
    chk("t5:data_post", cdbData, 32'd0);
    tick();
    chk("t5:last_late", 32'(isLastState), 32'd0);
    do_op("t5_ld3", OP_LOAD, 32'd3, 32'd0, 32'h0, QUE0, 0);

    // Test 6: require held high, two queued stores accepted back to back
    require   = 1'b1;
    op        = OP_STORE;
    baseIn    = 32'd10;
    offsetIn  = 32'd0;
    writeData = 32'h11112222;
    labelIn   = QUE0;
    for (int k = 0; k < 2 * (LAT + 1); k++) begin
      chk($sformatf("t6:avail_c%0d", k), 32'(available), 32'(k % (LAT + 1) == 0));
      chk($sformatf("t6:last_c%0d", k), 32'(isLastState), 32'(k % (LAT + 1) == LAT));
      chk($sformatf("t6:req_c%0d", k), 32'(cdbReq), 32'd0);
      tick();
      // queue pops on the isLastState edge and presents the next head
      if (k == LAT) begin
        baseIn    = 32'd11;
        writeData = 32'h33334444;
        labelIn   = QUE1;
      end
      if (k == 2 * (LAT + 1) - 2) require = 1'b0;
    end
    mmem[10] = 32'h11112222;
    mmem[11] = 32'h33334444;
    chk("t6:idle_end", 32'(available), 32'd1);
    do_op("t6_ld10", OP_LOAD, 32'd10, 32'd0, 32'h0, QUE2, 0);
    do_op("t6_ld11", OP_LOAD, 32'd8,  32'd3, 32'h0, QUE0, 2);

    chk("sb_drained", 32'(sbq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
